// File: rtl/shift_wb_stage_if.sv
// Handshake bundle between the shifter, the writeback stage and the register file.
// The in_* side carries shifter results; the wb_* side carries register-file writes.
interface shift_wb_stage_if #(
    parameter int RAW = 5
);
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_data;
    logic [3:0]     in_flags;
    logic [RAW-1:0] in_rd;
    logic           in_we;
    logic           in_setf;
    logic           wb_valid;
    logic           wb_ready;
    logic [31:0]    wb_data;
    logic [RAW-1:0] wb_rd;

    modport master (
        output in_valid, in_data, in_flags, in_rd, in_we, in_setf,
        input  in_ready,
        input  wb_valid, wb_data, wb_rd,
        output wb_ready
    );

    modport slave (
        input  in_valid, in_data, in_flags, in_rd, in_we, in_setf,
        output in_ready,
        output wb_valid, wb_data, wb_rd,
        input  wb_ready
    );
endinterface

// File: rtl/shift_wb_stage.sv
// Writeback/status stage behind the barrel shifter: in-order FIFO of results,
// register-file writes via valid/ready, NZCV committed at pop in program order.
module shift_wb_stage #(
    parameter int DEPTH = 2,
    parameter int RAW   = 5,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    shift_wb_stage_if.slave bus,
    output logic [3:0]    nzcv,
    output logic [CW-1:0] count
);
    typedef struct packed {
        logic [31:0]    data;
        logic [3:0]     flags;
        logic [RAW-1:0] rd;
        logic           we;
        logic           setf;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          empty;
    logic          push;
    logic          pop;

    assign head         = mem[rd_ptr];
    assign empty        = (count == '0);
    assign bus.in_ready = (count != CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    // Flag-only entries retire immediately; writes wait for the register file.
    assign pop          = !empty && (!head.we || bus.wb_ready);

    assign bus.wb_valid = !empty && head.we;
    assign bus.wb_data  = bus.wb_valid ? head.data : '0;
    assign bus.wb_rd    = bus.wb_valid ? head.rd : '0;

    // Entry storage: written on accepted pushes only, never cleared.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr] <= '{
                data:  bus.in_data,
                flags: bus.in_flags,
                rd:    bus.in_rd,
                we:    bus.in_we,
                setf:  bus.in_setf
            };
        end
    end

    // Pointers, occupancy and architectural NZCV; flush keeps NZCV untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            nzcv   <= 4'b0000;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head.setf) begin
                    nzcv <= head.flags;
                end
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_shift_wb_stage.sv
// Testbench for shift_wb_stage: table of single-entry vectors plus hand-written
// stall, flag-only, flush and push/pop sequences, with a write scoreboard.
module tb_shift_wb_stage;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        logic [4:0]  rd;
        logic        we;
        logic        setf;
        logic [3:0]  exp_nzcv;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [3:0] nzcv;
    logic [1:0] count;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];

    shift_wb_stage_if #(.RAW(5)) bus ();

    shift_wb_stage #(
        .DEPTH(2),
        .RAW(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus.slave),
        .nzcv(nzcv),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void drive(vec_t v);
        bus.in_valid = 1'b1;
        bus.in_data  = v.data;
        bus.in_flags = v.flags;
        bus.in_rd    = v.rd;
        bus.in_we    = v.we;
        bus.in_setf  = v.setf;
    endfunction

    function automatic void record(vec_t v);
        if (v.we) exp_q.push_back({v.rd, v.data});
    endfunction

    // Offer one entry from the posedge+1 phase; returns in that phase.
    task automatic offer(vec_t v);
        int n = 0;
        bit done = 0;
        drive(v);
        while (!done && n < 50) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                record(v);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout: rd %0d never accepted", v.rd);
        end
    endtask

    task automatic wait_empty(string nm);
        int n = 0;
        @(negedge clk);
        while (count != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, 64'(count), 64'd0);
        chk({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard on accepted writes, hold-during-stall, zero when empty.
    logic        prev_stall = 1'b0;
    logic [36:0] prev_wb;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_stall) begin
                    chk("stall_hold", {bus.wb_valid, bus.wb_rd, bus.wb_data},
                        {1'b1, prev_wb});
                end
                if (count == 0) begin
                    chk("empty_outputs", {bus.wb_valid, bus.wb_rd, bus.wb_data}, 64'd0);
                end
                if (bus.wb_valid && bus.wb_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected: got rd %0d data %h, none expected",
                                 bus.wb_rd, bus.wb_data);
                    end else begin
                        chk("wb_write", {bus.wb_rd, bus.wb_data}, exp_q.pop_front());
                    end
                end
                prev_stall = bus.wb_valid && !bus.wb_ready && !flush;
                prev_wb    = {bus.wb_rd, bus.wb_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    vec_t vt[6];
    vec_t v;
    vec_t x;
    vec_t y;

    initial begin
        vt[0] = '{32'hFFFF_FFFF, 4'b0100, 5'd7,  1'b1, 1'b1, 4'b0100};
        vt[1] = '{32'h0000_0000, 4'b1000, 5'd0,  1'b1, 1'b1, 4'b1000};
        vt[2] = '{32'h1234_5678, 4'b0010, 5'd31, 1'b1, 1'b0, 4'b1000};
        vt[3] = '{32'h8000_0001, 4'b0111, 5'd15, 1'b0, 1'b1, 4'b0111};
        vt[4] = '{32'hDEAD_BEEF, 4'b0001, 5'd9,  1'b0, 1'b0, 4'b0111};
        vt[5] = '{32'h0F0F_0F0F, 4'b1111, 5'd30, 1'b1, 1'b1, 4'b1111};

        reset        = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_flags = '0;
        bus.in_rd    = '0;
        bus.in_we    = 1'b0;
        bus.in_setf  = 1'b0;
        bus.wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_wb_bus", {bus.wb_rd, bus.wb_data}, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_nzcv", 64'(nzcv), 64'd0);
        @(posedge clk);
        #1;

        // Single write with flag commit, latency checked cycle by cycle.
        v = '{32'h0000_8000, 4'b0100, 5'd3, 1'b1, 1'b1, 4'b0100};
        drive(v);
        @(negedge clk);
        chk("t2_in_ready", 64'(bus.in_ready), 64'd1);
        record(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("t2_wb_data", 64'(bus.wb_data), 64'h0000_8000);
        chk("t2_wb_rd", 64'(bus.wb_rd), 64'd3);
        chk("t2_nzcv_pre", 64'(nzcv), 64'd0);
        @(negedge clk);
        chk("t2_nzcv", 64'(nzcv), 64'b0100);
        chk("t2_count", 64'(count), 64'd0);
        @(posedge clk);
        #1;

        // Table of single entries, each drained before the NZCV check.
        for (int i = 0; i < 6; i++) begin
            offer(vt[i]);
            wait_empty($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_nzcv", i), 64'(nzcv), 64'(vt[i].exp_nzcv));
        end

        // Backpressure: fill, hold a third entry upstream, then release.
        bus.wb_ready = 1'b0;
        offer('{32'hA000_0001, 4'b0000, 5'd1, 1'b1, 1'b0, 4'b0});
        offer('{32'hA000_0002, 4'b0000, 5'd2, 1'b1, 1'b0, 4'b0});
        fork
            offer('{32'hA000_0003, 4'b0000, 5'd3, 1'b1, 1'b0, 4'b0});
            begin
                @(negedge clk);
                chk("full_count", 64'(count), 64'd2);
                chk("full_in_ready", 64'(bus.in_ready), 64'd0);
                repeat (2) @(posedge clk);
                #1;
                bus.wb_ready = 1'b1;
                @(negedge clk);
                chk("full_pop_in_ready", 64'(bus.in_ready), 64'd0);
                chk("full_pop_count", 64'(count), 64'd2);
                @(negedge clk);
                chk("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
                chk("after_pop_count", 64'(count), 64'd1);
            end
        join
        wait_empty("stall");

        // Flag-only entry retires without the register file.
        bus.wb_ready = 1'b0;
        v = '{32'h0000_0000, 4'b1010, 5'd6, 1'b0, 1'b1, 4'b1010};
        drive(v);
        @(negedge clk);
        record(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fo_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("fo_count", 64'(count), 64'd1);
        chk("fo_nzcv_pre", 64'(nzcv), 64'b1111);
        @(negedge clk);
        chk("fo_nzcv", 64'(nzcv), 64'b1010);
        chk("fo_count_after", 64'(count), 64'd0);
        @(posedge clk);
        #1;

        // Flush with a full FIFO and a same-cycle flagged push.
        offer('{32'hB000_0004, 4'b0001, 5'd4, 1'b1, 1'b1, 4'b0});
        offer('{32'hB000_0005, 4'b0011, 5'd5, 1'b1, 1'b1, 4'b0});
        drive('{32'hB000_0006, 4'b1111, 5'd12, 1'b1, 1'b1, 4'b0});
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("fl_nzcv", 64'(nzcv), 64'b1010);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("fl_absent", 64'({count, bus.wb_valid}), 64'd0);
        chk("fl_nzcv_hold", 64'(nzcv), 64'b1010);
        @(posedge clk);
        #1;

        // Simultaneous push and pop at count=1.
        bus.wb_ready = 1'b1;
        x = '{32'h5555_0000, 4'b0101, 5'd10, 1'b1, 1'b0, 4'b0};
        y = '{32'hAAAA_0000, 4'b1001, 5'd11, 1'b1, 1'b0, 4'b0};
        drive(x);
        @(negedge clk);
        record(x);
        @(posedge clk);
        #1;
        drive(y);
        @(negedge clk);
        chk("pp_count", 64'(count), 64'd1);
        chk("pp_in_ready", 64'(bus.in_ready), 64'd1);
        record(y);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pp_count_hold", 64'(count), 64'd1);
        chk("pp_order", 64'(bus.wb_rd), 64'd11);
        @(posedge clk);
        #1;
        wait_empty("pp");
        chk("pp_nzcv", 64'(nzcv), 64'b1010);

        // Back-to-back burst at full throughput.
        for (int i = 0; i < 8; i++) begin
            offer('{32'($urandom), 4'b0000, 5'(i + 16), 1'b1, 1'b0, 4'b0});
        end
        wait_empty("burst");
        chk("burst_nzcv", 64'(nzcv), 64'b1010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_wb_stage.md
# shift_wb_stage

Writeback and status stage directly downstream of the 32-bit barrel shifter. It captures each shifter result together with its flags, destination register index and control bits in a small in-order FIFO. It presents register-file writes through a valid/ready handshake and commits the shifter's flags into an architectural NZCV status register in program order. It decouples the combinational shifter path from register-file backpressure.

## Interface
- DEPTH, 2, number of FIFO entries; power of two, ≥2.
- RAW, 5, width of the destination register index.

- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all queued entries.
- in_valid  in  1  an upstream result is offered.
- in_ready  out  1  the stage can accept a result this cycle.
- in_data  in  32  shifter data_out.
- in_flags  in  4  shifter flag_out, bit order {Z,N,C,V}.
- in_rd  in  RAW  destination register index.
- in_we  in  1  the result is written to the register file.
- in_setf  in  1  the result updates NZCV.
- wb_valid  out  1  a register-file write is presented.
- wb_ready  in  1  the register file accepts the write.
- wb_data  out  32  write data.
- wb_rd  out  RAW  write index.
- nzcv  out  4  architectural status {Z,N,C,V}.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Each entry holds {data, flags, rd, we, setf}. Entries are stored in a circular buffer with a read pointer and a write pointer; both pointers wrap at DEPTH.
- Push occurs when in_valid && in_ready.
- in_ready = (count != DEPTH). No pass-through when full, even if a pop happens in the same cycle.
- Head entry with we=1:
  - wb_valid = 1, wb_data = head.data, wb_rd = head.rd.
  - Pop occurs when wb_ready=1.
- Head entry with we=0:
  - wb_valid = 0.
  - The entry pops unconditionally in the cycle it is at the head (flag-only retire).
- When FIFO is empty: wb_valid = 0, wb_data = 0, wb_rd = 0.
- NZCV commit occurs at pop time only: if head.setf=1, nzcv <= head.flags, written on the same edge as the pop. Entries with setf=0 leave nzcv unchanged. Flags therefore retire in the same order as writes.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Priority: reset > flush > push/pop.
  - reset: pointers=0, count=0, nzcv=4'b0000.
  - flush: pointers=0, count=0. Any same-cycle push and pop are discarded. nzcv is unchanged, including no commit from the head entry.
- in_valid while in_ready=0: no state change. The upstream stage must hold its inputs stable.
- in_* contents are ignored when in_valid=0.

## Timing
- Reset values: in_ready=1, wb_valid=0, wb_data=0, wb_rd=0, nzcv=0, count=0.
- Latency: a push at edge N is visible at the head (wb_valid or flag-only retire) in cycle N+1. This is a 1-cycle minimum.
- A pop at edge N exposes the next entry in cycle N+1. Sustained throughput is 1 entry/cycle while wb_ready=1.
- nzcv reflects a committed entry from the cycle after its pop edge.
- wb_valid must not drop and wb_data/wb_rd must not change while wb_valid=1 && wb_ready=0, unless reset or flush is asserted.
- A full FIFO with simultaneous pop: in_ready stays 0 in that cycle and is 1 in the next cycle.
- Reset or flush mid-stream: takes effect at that edge. Outputs equal their reset values in the next cycle, except nzcv, which is held on flush.

## Test plan
- Reset held 2 cycles, then released -> in_ready=1, wb_valid=0, count=0, nzcv=4'b0000.
- Push data=32'h0000_8000, flags=4'b0100, rd=3, we=1, setf=1, with wb_ready=1 -> next cycle wb_valid=1, wb_data=32'h0000_8000, wb_rd=3; the following cycle nzcv=4'b0100, count=0.
- DEPTH=2, wb_ready=0, offer rd=1, 2, 3 on consecutive cycles -> after 2 pushes count=2, in_ready=0, third entry held upstream. Raise wb_ready -> writes appear in rd order 1, 2, 3, with wb_data stable throughout the stall.
- Push we=0, setf=1, flags=4'b1010 -> wb_valid stays 0; nzcv=4'b1010 two cycles after the push; count returns to 0.
- count=2 with wb_ready=0; assert flush together with a valid push of setf=1 -> next cycle count=0, wb_valid=0, nzcv unchanged, pushed entry absent.
- count=1, wb_ready=1, push and pop in the same cycle -> count stays 1, order preserved; a setf=0 entry leaves nzcv unchanged.
